// File: rtl/arp_pkg.sv
//==============================================================================
// Module : arp_pkg
// Brief  : Shared ARP field constants and FSM encoding for encoder/decoder.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package arp_pkg;

    localparam logic [15:0] ARP_HW_TYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_PROTO_IPV4  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'h06;
    localparam logic [7:0]  ARP_PLEN        = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
    localparam int          ARP_LEN         = 28;
    localparam int          ARP_PAD_LEN     = 46;

    typedef enum logic [1:0] {
        ARP_IDLE   = 2'd0,
        ARP_SEND   = 2'd1,
        ARP_FINISH = 2'd2
    } arp_state_e;

endpackage

`default_nettype wire

// File: rtl/arp_encode8.sv
//==============================================================================
// Module : arp_encode8
// Brief  : Serialises a 28-byte ARP packet MSB-first on a valid/ready stream.
//          Define ARP_PAD_EN to append 18 zero bytes (46-byte payload).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arp_encode8
    import arp_pkg::*;
#(
    parameter int          AVL_SIZE   = 8,
    parameter int          AVL_WORDS  = 28,
    parameter int          MAC_SIZE   = 48,
    parameter int          IP_SIZE    = 32,
    parameter int          BYTE_SIZE  = 8,
    parameter logic [15:0] HW_TYPE    = ARP_HW_TYPE_ETH,
    parameter logic [15:0] PROTO_TYPE = ARP_PROTO_IPV4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [15:0]         operation,
    input  logic [MAC_SIZE-1:0] sender_hardware_address,
    input  logic [IP_SIZE-1:0]  sender_protocol_address,
    input  logic [MAC_SIZE-1:0] target_hardware_address,
    input  logic [IP_SIZE-1:0]  target_protocol_address,
    output logic [AVL_SIZE-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                data_out_sop,
    output logic                data_out_eop,
    output logic                busy,
    output logic                done
);

    localparam int c_PKT_W = AVL_WORDS * BYTE_SIZE;
    localparam int c_CNT_W = 6;
`ifdef ARP_PAD_EN
    localparam int c_NBYTES = ARP_PAD_LEN;
`else
    localparam int c_NBYTES = AVL_WORDS;
`endif
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NBYTES - 1);

    arp_state_e         r_state;
    arp_state_e         w_next_state;
    logic [c_PKT_W-1:0] r_pkt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_accept;
    logic               w_last;

    assign w_load   = (r_state == ARP_IDLE) && start;
    assign w_accept = (r_state == ARP_SEND) && data_out_ready;
    assign w_last   = (r_cnt == c_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARP_IDLE:   if (start) w_next_state = ARP_SEND;
            ARP_SEND:   if (w_accept && w_last) w_next_state = ARP_FINISH;
            ARP_FINISH: w_next_state = ARP_IDLE;
            default:    w_next_state = ARP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Zeros shift in behind the payload, so pad bytes come for free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_pkt <= {HW_TYPE, PROTO_TYPE, ARP_HLEN, ARP_PLEN, operation,
                      sender_hardware_address, sender_protocol_address,
                      target_hardware_address, target_protocol_address};
            r_cnt <= '0;
        end else if (w_accept) begin
            r_pkt <= {r_pkt[c_PKT_W-BYTE_SIZE-1:0], {BYTE_SIZE{1'b0}}};
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign data_out       = r_pkt[c_PKT_W-1 -: AVL_SIZE];
    assign data_out_valid = (r_state == ARP_SEND);
    assign data_out_sop   = (r_state == ARP_SEND) && (r_cnt == '0);
    assign data_out_eop   = (r_state == ARP_SEND) && w_last;
    assign busy           = (r_state == ARP_SEND);
    assign done           = (r_state == ARP_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_arp_encode8.sv
//==============================================================================
// Module : tb_arp_encode8
// Brief  : Randomised self-checking bench for arp_encode8 (honours ARP_PAD_EN).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_arp_encode8;

`ifdef ARP_PAD_EN
    localparam int c_NB = 46;
`else
    localparam int c_NB = 28;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] operation = '0;
    logic [47:0] sha = '0;
    logic [31:0] spa = '0;
    logic [47:0] tha = '0;
    logic [31:0] tpa = '0;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b0;
    logic        data_out_sop;
    logic        data_out_eop;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arp_encode8 u_dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .operation               (operation),
        .sender_hardware_address (sha),
        .sender_protocol_address (spa),
        .target_hardware_address (tha),
        .target_protocol_address (tpa),
        .data_out                (data_out),
        .data_out_valid          (data_out_valid),
        .data_out_ready          (data_out_ready),
        .data_out_sop            (data_out_sop),
        .data_out_eop            (data_out_eop),
        .busy                    (busy),
        .done                    (done)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference packet: field list expanded to bytes, big-endian, then padding.
    function automatic void build_ref(input logic [15:0] op, input logic [47:0] a_sha,
                                      input logic [31:0] a_spa, input logic [47:0] a_tha,
                                      input logic [31:0] a_tpa, ref logic [7:0] q[$]);
        logic [15:0] hw;
        logic [15:0] pr;
        hw = 16'h0001;
        pr = 16'h0800;
        q.delete();
        for (int i = 1; i >= 0; i--) q.push_back(hw[8*i +: 8]);
        for (int i = 1; i >= 0; i--) q.push_back(pr[8*i +: 8]);
        q.push_back(8'd6);
        q.push_back(8'd4);
        for (int i = 1; i >= 0; i--) q.push_back(op[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(a_sha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(a_spa[8*i +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(a_tha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(a_tpa[8*i +: 8]);
        while (q.size() < c_NB) q.push_back(8'h00);
    endfunction

    // rmode 0: ready held high; 1: random ready. Negative indices disable options.
    task automatic send_pkt(input logic [15:0] op, input logic [47:0] a_sha,
                            input logic [31:0] a_spa, input logic [47:0] a_tha,
                            input logic [31:0] a_tpa, input int rmode,
                            input int stall_at, input int restart_at, input int reset_at);
        logic [7:0] exp_q[$];
        logic [7:0] prev_data;
        bit         prev_stall;
        bit         first;
        int         idx;
        int         cycles;
        int         stall_cnt;
        build_ref(op, a_sha, a_spa, a_tha, a_tpa, exp_q);

        @(negedge clk);
        check_val("idle_valid", data_out_valid, 1'b0);
        check_val("idle_busy", busy, 1'b0);
        check_val("idle_done", done, 1'b0);
        operation = op;
        sha = a_sha;
        spa = a_spa;
        tha = a_tha;
        tpa = a_tpa;
        start = 1'b1;
        data_out_ready = 1'b0;

        idx = 0;
        cycles = 0;
        stall_cnt = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        first = 1'b1;
        while (idx < c_NB && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (reset_at >= 0 && idx == reset_at) begin
                #1 reset_n = 1'b0;
                #1;
                check_val("rst_valid", data_out_valid, 1'b0);
                check_val("rst_busy", busy, 1'b0);
                check_val("rst_done", done, 1'b0);
                check_val("rst_eop", data_out_eop, 1'b0);
                check_val("rst_data", data_out, 8'h00);
                data_out_ready = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (first) begin
                // Fields changed after acceptance must not reach the packet.
                sha = 48'hFFFF_FFFF_FFFF;
                spa = $urandom;
                tha = {$urandom, $urandom};
                tpa = $urandom;
                operation = 16'hDEAD;
                check_val("lat_sop", data_out_sop, 1'b1);
                first = 1'b0;
            end
            check_val("valid_held", data_out_valid, 1'b1);
            check_val("busy_held", busy, 1'b1);
            check_val("no_done", done, 1'b0);
            if (prev_stall) check_val("stall_stable", data_out, prev_data);
            if (restart_at >= 0 && idx == restart_at) begin
                operation = 16'h0001;
                start = 1'b1;
            end
            if (rmode == 0) data_out_ready = 1'b1;
            else if (idx == stall_at && stall_cnt < 10) begin
                data_out_ready = 1'b0;
                stall_cnt++;
            end else data_out_ready = 1'($urandom_range(0, 1));
            if (data_out_ready) begin
                check_val($sformatf("byte%0d", idx), data_out, exp_q[idx]);
                check_val("sop", data_out_sop, idx == 0);
                check_val("eop", data_out_eop, idx == c_NB - 1);
                idx++;
            end
            prev_stall = !data_out_ready;
            prev_data = data_out;
        end
        if (idx < c_NB) check_val("timeout", 1'b1, 1'b0);
        if (rmode == 0) check_val("beats", cycles, c_NB);

        @(negedge clk);
        start = 1'b0;
        check_val("done_pulse", done, 1'b1);
        check_val("fin_valid", data_out_valid, 1'b0);
        check_val("fin_busy", busy, 1'b0);
        check_val("fin_eop", data_out_eop, 1'b0);
        data_out_ready = 1'($urandom_range(0, 1));
        if (restart_at >= 0) begin
            operation = 16'h0001;
            start = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_valid", data_out_valid, 1'b0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        check_val("reset_sop", data_out_sop, 1'b0);
        check_val("reset_data", data_out, 8'h00);
        reset_n = 1'b1;

        send_pkt(16'd2, 48'h0123456789AB, 32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002, 0, -1, -1, -1);
        send_pkt(16'd2, 48'h0123456789AB, 32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002, 1, 13, -1, -1);
        send_pkt(16'd2, 48'h0123456789AB, 32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002, 0, -1, 5, -1);
        send_pkt(16'd1, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom, 0, -1, -1, -1);
        send_pkt(16'd2, 48'h0123456789AB, 32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002, 0, -1, -1, 10);
        send_pkt(16'd2, 48'h0123456789AB, 32'hC0A80001, 48'hAABBCCDDEEFF, 32'hC0A80002, 0, -1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            send_pkt(16'($urandom_range(1, 2)), {$urandom, $urandom}, $urandom,
                     {$urandom, $urandom}, $urandom, 1, $urandom_range(0, c_NB - 1), -1, -1);
        end

        @(negedge clk);
        check_val("end_idle", busy, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/arp_encode8.md
Name: arp_encode8

Overview:
Builds a 28-byte Ethernet/IPv4 ARP packet and streams it out one byte per beat, MSB-first. It is the transmit-side counterpart of the ARP receive decoder. It sits between the ARP responder logic, which supplies the fields, and the 8-bit Ethernet TX framer, which consumes the bytes. The stream uses a valid/ready handshake, so the framer can stall it.

Parameters:
AVL_SIZE, 8, stream data width in bits (only 8 supported)
AVL_WORDS, 28, ARP payload length in bytes
MAC_SIZE, 48, hardware address width
IP_SIZE, 32, protocol address width
BYTE_SIZE, 8, byte width
HW_TYPE, 16'h0001, hardware type field (Ethernet)
PROTO_TYPE, 16'h0800, protocol type field (IPv4)

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  request to send one packet; accepted only in IDLE
operation  in  16  ARP opcode (1 = request, 2 = reply)
sender_hardware_address  in  48  SHA
sender_protocol_address  in  32  SPA
target_hardware_address  in  48  THA
target_protocol_address  in  32  TPA
data_out  out  8  stream byte
data_out_valid  out  1  data_out is valid
data_out_ready  in  1  downstream accepts the byte when high together with valid
data_out_sop  out  1  high with the first byte
data_out_eop  out  1  high with the last byte
busy  out  1  high from start acceptance until the last byte is accepted
done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, byte counter = 0, packet register = 0, and every output low, including data_out = 8'h00.
- States:
  - IDLE
  - SEND
  - FINISH
- IDLE:
  - busy = 0.
  - On start = 1, load the 224-bit packet register in this order: {HW_TYPE, PROTO_TYPE, 8'h06, 8'h04, operation, SHA, SPA, THA, TPA}.
  - Clear the counter and go to SEND.
- Latency:
  - If start is sampled at edge N, data_out_valid = 1 with byte 0 (8'h00) after edge N.
  - Byte 0 has data_out_sop = 1.
- SEND:
  - data_out = packet register[223:216].
  - data_out_valid is held at 1.
  - data_out and valid stay stable while data_out_ready = 0.
  - On valid & ready: shift the register left 8 bits and increment the counter.
  - data_out_eop = 1 when counter == AVL_WORDS-1.
  - When the byte with eop is accepted: go to FINISH and drop valid on the next cycle.
  - There are no bubbles while ready is held high: 28 consecutive beats.
- FINISH:
  - done = 1 for exactly one cycle, busy = 0, then return to IDLE.
  - start is ignored in FINISH.
  - The minimum spacing between packets is therefore 30 cycles with continuous ready.
- start while busy or in FINISH is ignored; no queueing.
- The input fields are sampled only at start acceptance. Later changes to them do not affect the packet in flight.
- Reset asserted mid-packet aborts it immediately:
  - No eop and no done.
  - The downstream framer must discard the partial frame.
- data_out_ready high while valid is low has no effect.
- busy is combinationally equal to (state == SEND) and is registered with the state.

Optional Feature:
ARP_PAD_EN:
- Defined: after the 28 ARP bytes, emit 18 bytes of 8'h00 so the payload reaches the 46-byte Ethernet minimum.
  - eop moves to byte 45.
  - The counter runs 0..45.
  - done follows acceptance of byte 45.
- Undefined: exactly 28 bytes are sent, with eop on byte 27; the TX framer handles padding.

Decomposition:
- Shared package (arp_pkg), holding:
  - ARP_HW_TYPE_ETH = 16'h0001
  - ARP_PROTO_IPV4 = 16'h0800
  - ARP_HLEN = 8'h06
  - ARP_PLEN = 8'h04
  - ARP_OP_REQUEST = 16'h0001
  - ARP_OP_REPLY = 16'h0002
  - ARP_LEN = 28
  - ARP_PAD_LEN = 46
  - The state encoding
- The package is shared with the decoder.
- No sub-module: a single FSM plus a shift register. A separate serializer would be a thin wrapper.

Test Plan:
1. Reply packet:
   - Stimulus: reset, then start with op = 2, SHA = 0x0123456789AB, SPA = 0xC0A80001, THA = 0xAABBCCDDEEFF, TPA = 0xC0A80002, ready held 1.
   - Response: bytes 00 01 08 00 06 04 00 02 01 23 45 67 89 AB C0 A8 00 01 AA BB CC DD EE FF C0 A8 00 02; sop on byte 0, eop on byte 27; done exactly 1 cycle after eop accepted.
2. Backpressure:
   - Stimulus: same packet, ready toggled by a random 50% pattern, including a 10-cycle stall on byte 13.
   - Response: identical byte sequence; data_out stable while ready = 0; no byte dropped or duplicated.
3. Start while busy:
   - Stimulus: second start with op = 1 at byte 5.
   - Response: it is ignored; the packet still carries op = 2 and only one done is produced.
   - Stimulus: start 1 cycle after done.
   - Response: it is accepted; byte 7 of the new packet = 8'h01.
4. Field change mid-packet:
   - Stimulus: alter SHA to 0xFFFFFFFFFFFF after start.
   - Response: the output still carries 0x0123456789AB.
5. Reset mid-packet:
   - Stimulus: reset_n pulsed low asynchronously at byte 10.
   - Response: valid, busy and done go to 0 immediately; no eop; the next start emits a full, correct packet.
6. ARP_PAD_EN defined:
   - Response: 46 beats; bytes 28–45 = 00; eop on byte 45 only.
